alarm_multidigit: RTL

ALARM_MULTIDIGIT -- requirements
Module: alarm_multidigit

---
 rtl/alarm_pkg.sv | 27 ++
 rtl/bcd_digit.sv | 36 +++
 rtl/alarm_multidigit.sv | 118 +++++++++++
 3 files changed

// File: rtl/alarm_pkg.sv
// Shared constants for the multi-digit BCD alarm counter:
// digit width, alarm reset digit and 7-segment encoding.
package alarm_pkg;

    localparam int DIGIT_W = 4;
    localparam logic [DIGIT_W-1:0] ALARM_RST_DIGIT = 4'd9;

    // Segment order is {g,f,e,d,c,b,a}, active-high.
    function automatic logic [6:0] seg7(input logic [DIGIT_W-1:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b0111111;
            4'd1:    s = 7'b0000110;
            4'd2:    s = 7'b1011011;
            4'd3:    s = 7'b1001111;
            4'd4:    s = 7'b1100110;
            4'd5:    s = 7'b1101101;
            4'd6:    s = 7'b1111101;
            4'd7:    s = 7'b0000111;
            4'd8:    s = 7'b1111111;
            4'd9:    s = 7'b1101111;
            default: s = 7'b0000000;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit of the up/down counter with ripple carry/borrow.
// co is combinational so the chain settles within one clock.
module bcd_digit
    import alarm_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               ci,
    input  logic               up,
    output logic [DIGIT_W-1:0] q,
    output logic               co
);

    logic [DIGIT_W-1:0] nxt;

    always_comb begin
        nxt = q;
        if (up)
            nxt = (q >= 4'd9) ? 4'd0 : q + 4'd1;
        else
            nxt = (q == 4'd0) ? 4'd9 : q - 4'd1;
    end

    assign co = ci & (up ? (q == 4'd9) : (q == 4'd0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            q <= '0;
        else if (clr)
            q <= '0;
        else if (ci)
            q <= nxt;
    end

endmodule

// File: rtl/alarm_multidigit.sv
// Multi-digit BCD up/down counter with latched alarm output
// and a multiplexed 7-segment display driver.
module alarm_multidigit
    import alarm_pkg::*;
#(
    parameter int NDIGITS  = 4,
    parameter int TICK_DIV = 2500000,
    parameter int SCAN_DIV = 4000
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    input  logic                       up,
    input  logic                       alarm_ld,
    input  logic [DIGIT_W*NDIGITS-1:0] alarm_val,
    input  logic                       alarm_ack,
    output logic                       sp,
    output logic [DIGIT_W*NDIGITS-1:0] count,
    output logic [6:0]                 o,
    output logic [NDIGITS-1:0]         com
);

    localparam int PW = $clog2(TICK_DIV);
    localparam int SW = $clog2(SCAN_DIV);
    localparam int IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

    logic [PW-1:0]              pre;
    logic                       step;
    logic [NDIGITS:0]           cy;
    logic                       wrap_unused;
    logic [DIGIT_W*NDIGITS-1:0] alarm_q;
    logic                       match;
    logic                       match_q;
    logic                       hit;
    logic [SW-1:0]              sc;
    logic                       adv;
    logic [IW-1:0]              idx;
    logic [DIGIT_W-1:0]         cur_d;

    assign step = en && (pre == PW'(TICK_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pre <= '0;
        else if (!en || step)
            pre <= '0;
        else
            pre <= pre + 1'b1;
    end

    assign cy[0]       = step;
    assign wrap_unused = cy[NDIGITS];

    for (genvar gi = 0; gi < NDIGITS; gi++) begin : g_dig
        bcd_digit u_dig (
            .clk   (clk),
            .rst_n (rst_n),
            .clr   (!en),
            .ci    (cy[gi]),
            .up    (up),
            .q     (count[DIGIT_W*gi +: DIGIT_W]),
            .co    (cy[gi+1])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            alarm_q <= {NDIGITS{ALARM_RST_DIGIT}};
        else if (alarm_ld)
            alarm_q <= alarm_val;
    end

    // Only the rising edge of a match sets sp, so a held match
    // cannot re-arm the alarm after it has been acknowledged.
    assign match = en && (count == alarm_q);
    assign hit   = match && !match_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            match_q <= 1'b0;
            sp      <= 1'b0;
        end else begin
            match_q <= match;
            if (!en)
                sp <= 1'b0;
            else if (hit)
                sp <= 1'b1;
            else if (alarm_ack)
                sp <= 1'b0;
        end
    end

    assign adv = (sc == SW'(SCAN_DIV - 1));

    always_comb begin
        cur_d = '0;
        for (int i = 0; i < NDIGITS; i++)
            if (idx == IW'(i))
                cur_d = count[DIGIT_W*i +: DIGIT_W];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sc  <= '0;
            idx <= '0;
            o   <= '0;
            com <= '0;
        end else if (adv) begin
            sc  <= '0;
            idx <= (idx == IW'(NDIGITS - 1)) ? '0 : idx + 1'b1;
            o   <= seg7(cur_d);
            com <= NDIGITS'(1) << idx;
        end else begin
            sc  <= sc + 1'b1;
        end
    end

endmodule
